// File: rtl/hack_pkg.sv
// Shared types and constants for the Hack control/register stage.
package hack_pkg;

  typedef enum logic [1:0] {
    StFetch  = 2'd0,
    StMread  = 2'd1,
    StExec   = 2'd2,
    StMwrite = 2'd3
  } state_e;

  // Instruction-register field positions
  localparam int unsigned TYPE_BIT = 15;
  localparam int unsigned A_BIT    = 12;
  localparam int unsigned C_MSB    = 11;
  localparam int unsigned C_LSB    = 6;
  localparam int unsigned DEST_A   = 5;
  localparam int unsigned DEST_D   = 4;
  localparam int unsigned DEST_M   = 3;
  localparam int unsigned J_MSB    = 2;

  // Common ALU control codes (zx,nx,zy,ny,f,no)
  localparam logic [5:0] ALU_ZERO     = 6'b101010;
  localparam logic [5:0] ALU_ONE      = 6'b111111;
  localparam logic [5:0] ALU_X        = 6'b001100;
  localparam logic [5:0] ALU_X_PLUS_Y = 6'b000010;

endpackage

// File: rtl/hack_jump_unit.sv
// Combinational jump decision from the jjj field and the ALU flags.
module hack_jump_unit (
  input  logic [2:0] jjj,
  input  logic       zr,
  input  logic       ng,
  output logic       take
);

  // jjj bits select lt / eq / gt; 111 therefore always jumps
  always_comb begin
    take = (jjj[2] & ng) | (jjj[1] & zr) | (jjj[0] & ~ng & ~zr);
  end

endmodule

// File: rtl/hack_cpu_ctrl.sv
// Multi-cycle Hack control stage: holds A/D/PC, fetches, sequences M accesses.
module hack_cpu_ctrl
  import hack_pkg::*;
#(
  parameter logic [14:0] RESET_PC = 15'h0000,
  parameter int unsigned ADDR_W   = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              instr_valid,
  input  logic [15:0]       instr,
  output logic              instr_ready,
  output logic [ADDR_W-1:0] pc,
  output logic [15:0]       alu_x,
  output logic [15:0]       alu_y,
  output logic [5:0]        alu_c,
  input  logic [15:0]       alu_out,
  input  logic              alu_zr,
  input  logic              alu_ng,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic [15:0]       mem_wdata,
  input  logic [15:0]       mem_rdata,
  input  logic              mem_ack
);

  state_e            state_q, state_d;
  logic [15:0]       a_q, a_d;
  logic [15:0]       d_q, d_d;
  logic [15:0]       ir_q, ir_d;
  logic [15:0]       m_q, m_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic [15:0]       wdata_q, wdata_d;
  logic              take;

  // Type and don't-care bits are only looked at on the incoming word
  logic unused_ir;
  assign unused_ir = ^ir_q[15:13];

  hack_jump_unit u_jump (
    .jjj  (ir_q[J_MSB:0]),
    .zr   (alu_zr),
    .ng   (alu_ng),
    .take (take)
  );

  // State and architectural registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StFetch;
      a_q     <= '0;
      d_q     <= '0;
      ir_q    <= '0;
      m_q     <= '0;
      pc_q    <= RESET_PC;
      waddr_q <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      d_q     <= d_d;
      ir_q    <= ir_d;
      m_q     <= m_d;
      pc_q    <= pc_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
    end
  end

  // Next-state and register updates per phase
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    d_d     = d_q;
    ir_d    = ir_q;
    m_d     = m_q;
    pc_d    = pc_q;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    unique case (state_q)
      StFetch: begin
        if (instr_valid) begin
          ir_d = instr;
          if (!instr[TYPE_BIT]) begin
            a_d  = instr;
            pc_d = pc_q + 1'b1;
          end else if (instr[A_BIT]) begin
            state_d = StMread;
          end else begin
            state_d = StExec;
          end
        end
      end
      StMread: begin
        if (mem_ack) begin
          m_d     = mem_rdata;
          state_d = StExec;
        end
      end
      StExec: begin
        if (ir_q[DEST_A]) a_d = alu_out;
        if (ir_q[DEST_D]) d_d = alu_out;
        // Jump target and write address both use A before this update
        pc_d = take ? a_q[ADDR_W-1:0] : pc_q + 1'b1;
        if (ir_q[DEST_M]) begin
          waddr_d = a_q[ADDR_W-1:0];
          wdata_d = alu_out;
          state_d = StMwrite;
        end else begin
          state_d = StFetch;
        end
      end
      StMwrite: begin
        if (mem_ack) state_d = StFetch;
      end
      default: state_d = StFetch;
    endcase
  end

  // Outputs decoded from state and registers
  always_comb begin
    instr_ready = (state_q == StFetch);
    mem_rd      = (state_q == StMread);
    mem_wr      = (state_q == StMwrite);
    mem_addr    = (state_q == StMread) ? a_q[ADDR_W-1:0] : waddr_q;
    mem_wdata   = wdata_q;
    pc          = pc_q;
    alu_x       = d_q;
    alu_y       = ir_q[A_BIT] ? m_q : a_q;
    alu_c       = ir_q[C_MSB:C_LSB];
  end

endmodule

// File: tb/tb_hack_cpu_ctrl.sv
// Self-checking bench for hack_cpu_ctrl with an ALU, a memory responder and a model.
module tb_hack_cpu_ctrl;

  logic        clk;
  logic        rst_n;
  logic        instr_valid;
  logic [15:0] instr;
  logic        instr_ready;
  logic [14:0] pc;
  logic [15:0] alu_x, alu_y;
  logic [5:0]  alu_c;
  logic [15:0] alu_out;
  logic        alu_zr, alu_ng;
  logic [14:0] mem_addr;
  logic        mem_rd, mem_wr;
  logic [15:0] mem_wdata, mem_rdata;
  logic        mem_ack;

  int errors = 0;
  int checks = 0;

  hack_cpu_ctrl #(.RESET_PC(15'h0000), .ADDR_W(15)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .instr_valid (instr_valid),
    .instr       (instr),
    .instr_ready (instr_ready),
    .pc          (pc),
    .alu_x       (alu_x),
    .alu_y       (alu_y),
    .alu_c       (alu_c),
    .alu_out     (alu_out),
    .alu_zr      (alu_zr),
    .alu_ng      (alu_ng),
    .mem_addr    (mem_addr),
    .mem_rd      (mem_rd),
    .mem_wr      (mem_wr),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata),
    .mem_ack     (mem_ack)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference Hack ALU
  function automatic logic [15:0] alu_fn(logic [15:0] x, logic [15:0] y, logic [5:0] c);
    logic [15:0] xx, yy, o;
    xx = c[5] ? 16'h0000 : x;
    if (c[4]) xx = ~xx;
    yy = c[3] ? 16'h0000 : y;
    if (c[2]) yy = ~yy;
    o = c[1] ? xx + yy : xx & yy;
    if (c[0]) o = ~o;
    return o;
  endfunction

  always_comb begin
    alu_out = alu_fn(alu_x, alu_y, alu_c);
    alu_zr  = (alu_out == 16'h0000);
    alu_ng  = alu_out[15];
  end

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Memory responder: acks after ack_delay idle cycles, stray ack when idle
  logic [15:0] dmem [int];
  int          ack_delay = 0;
  int          cnt = 0;
  logic        stray_ack = 1'b0;

  initial begin
    mem_ack   = 1'b0;
    mem_rdata = 16'h0000;
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      mem_ack = 1'b0;
      cnt     = 0;
    end else if (mem_rd || mem_wr) begin
      if (cnt >= ack_delay) begin
        mem_ack = 1'b1;
        cnt     = 0;
        if (mem_rd) mem_rdata = dmem.exists(int'(mem_addr)) ? dmem[int'(mem_addr)] : 16'h0000;
        if (mem_wr) dmem[int'(mem_addr)] = mem_wdata;
      end else begin
        mem_ack = 1'b0;
        cnt++;
      end
    end else begin
      mem_ack = stray_ack;
    end
  end

  // Behavioural model: 0 fetch, 1 waiting for read data, 2 execute, 3 waiting for write ack
  int          mph;
  logic [15:0] ma, md, mir, mm, mwd;
  logic [14:0] mpc, mwa;
  logic [15:0] m_r;
  logic        m_take;

  always_comb begin
    m_r    = alu_fn(md, mir[12] ? mm : ma, mir[11:6]);
    m_take = (mir[2] && $signed(m_r) < 0) || (mir[1] && m_r == 16'h0000) ||
             (mir[0] && $signed(m_r) > 0);
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mph <= 0; ma <= '0; md <= '0; mir <= '0; mm <= '0;
      mpc <= 15'h0000; mwa <= '0; mwd <= '0;
    end else begin
      case (mph)
        0: if (instr_valid) begin
          mir <= instr;
          if (!instr[15]) begin
            ma  <= instr;
            mpc <= mpc + 15'd1;
          end else begin
            mph <= instr[12] ? 1 : 2;
          end
        end
        1: if (mem_ack) begin
          mm  <= mem_rdata;
          mph <= 2;
        end
        2: begin
          if (mir[5]) ma <= m_r;
          if (mir[4]) md <= m_r;
          mpc <= m_take ? ma[14:0] : mpc + 15'd1;
          if (mir[3]) begin
            mwa <= ma[14:0];
            mwd <= m_r;
            mph <= 3;
          end else begin
            mph <= 0;
          end
        end
        default: if (mem_ack) mph <= 0;
      endcase
    end
  end

  // Every-cycle compare against the model
  always @(negedge clk) begin
    check("ready", instr_ready, mph == 0);
    check("mem_rd", mem_rd, mph == 1);
    check("mem_wr", mem_wr, mph == 3);
    check("pc", pc, mpc);
    check("alu_x", alu_x, md);
    check("alu_y", alu_y, mir[12] ? mm : ma);
    check("alu_c", alu_c, mir[11:6]);
    check("mem_addr", mem_addr, (mph == 1) ? ma[14:0] : mwa);
    check("mem_wdata", mem_wdata, mwd);
  end

  // Called at a falling edge; returns at the first falling edge with ready high
  task automatic wait_ready();
    int n;
    n = 0;
    while (!instr_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) check("ready_timeout", 32'd0, 32'd1);
  endtask

  task automatic send(logic [15:0] w);
    wait_ready();
    instr_valid = 1'b1;
    instr       = w;
    @(negedge clk);
    instr_valid = 1'b0;
  endtask

  initial begin
    int n;
    rst_n       = 1'b0;
    instr_valid = 1'b0;
    instr       = 16'h0000;
    dmem[7]     = 16'h1234;
    @(negedge clk);
    check("rst_pc", pc, 15'h0000);
    check("rst_ready", instr_ready, 1'b1);
    check("rst_rd_wr", {mem_rd, mem_wr}, 2'b00);
    check("rst_addr_data", {mem_addr, mem_wdata}, 31'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // 1: A-instruction
    send(16'h0005);
    check("t1_pc", pc, 15'd1);
    check("t1_a", alu_y, 16'd5);
    check("t1_ready", instr_ready, 1'b1);

    // 2: D=A
    send(16'hEC10);
    check("t2_alu_c", alu_c, 6'b110000);
    wait_ready();
    check("t2_d", alu_x, 16'd5);
    check("t2_pc", pc, 15'd2);

    // 3: D=M with ack in the third read cycle
    ack_delay = 2;
    send(16'h0007);
    send(16'hFC10);
    n = 0;
    while (mem_rd && n < 20) begin
      check("t3_addr", mem_addr, 15'd7);
      n++;
      @(negedge clk);
    end
    check("t3_rd_cycles", n, 3);
    wait_ready();
    check("t3_d", alu_x, 16'h1234);
    check("t3_pc", pc, 15'd4);

    // 4: AM=D+A with D=5, A=9
    ack_delay = 1;
    send(16'h0005);
    send(16'hEC10);
    send(16'h0009);
    send(16'hE0A8);
    @(negedge clk);
    check("t4_wr", mem_wr, 1'b1);
    check("t4_waddr", mem_addr, 15'd9);
    check("t4_wdata", mem_wdata, 16'd14);
    wait_ready();
    check("t4_mem9", dmem.exists(9) ? dmem[9] : 16'hDEAD, 16'd14);
    check("t4_a", alu_y, 16'd14);
    check("t4_pc", pc, 15'd8);

    // 5: D;JEQ taken with D=0, not taken with D=1
    ack_delay = 0;
    send(16'h0040);
    send(16'hEA90);
    send(16'hE302);
    wait_ready();
    check("t5_jeq_taken", pc, 15'h0040);
    send(16'hEFD0);
    send(16'hE302);
    wait_ready();
    check("t5_jeq_not", pc, 15'h0042);

    // 6: unconditional jump to 7FFF, then wrap
    send(16'h7FFF);
    send(16'hEA87);
    wait_ready();
    check("t6_jmp", pc, 15'h7FFF);
    send(16'h0005);
    check("t6_wrap", pc, 15'h0000);

    // Reset while a read is outstanding
    ack_delay = 100;
    send(16'h0007);
    send(16'hFC10);
    @(negedge clk);
    check("rst_mid_rd", mem_rd, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check("rst_mid_rd_drop", mem_rd, 1'b0);
    check("rst_mid_pc", pc, 15'h0000);
    @(negedge clk);
    rst_n     = 1'b1;
    stray_ack = 1'b1;
    ack_delay = 0;
    repeat (3) begin
      @(negedge clk);
      check("stray_ack_ready", instr_ready, 1'b1);
    end
    stray_ack = 1'b0;
    @(negedge clk);
    send(16'h0003);
    check("post_rst_pc", pc, 15'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/hack_cpu_ctrl.md
Name: hack_cpu_ctrl

Overview:
Multi-cycle Hack control/register stage that drives the 16-bit Hack ALU (x, y, 6-bit control in zx,nx,zy,ny,f,no order) and consumes its out/zr/ng result.
- Holds A, D and PC.
- Fetches instructions over a valid/ready handshake and sequences M reads and writes over an ack-based memory port.
- Decides jumps from the ALU flags.

Parameters:
RESET_PC, 15'h0000, PC value loaded on reset
ADDR_W, 15, width of PC and data address (fixed 15 for Hack; A[14:0] used)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
instr_valid  in  1  instruction word available
instr  in  16  instruction word
instr_ready  out  1  block accepts instruction this cycle
pc  out  15  address of next instruction to fetch
alu_x  out  16  ALU x operand (D register)
alu_y  out  16  ALU y operand (A or latched M)
alu_c  out  6  ALU control, IR[11:6]
alu_out  in  16  ALU result (combinational)
alu_zr  in  1  ALU zero flag
alu_ng  in  1  ALU negative flag
mem_addr  out  15  data memory address
mem_rd  out  1  read request, held until mem_ack
mem_wr  out  1  write request, held until mem_ack
mem_wdata  out  16  write data
mem_rdata  in  16  read data, valid with mem_ack
mem_ack  in  1  memory completes current request

Behaviour:
- Reset (async, rst_n=0):
  - Registers: A=0, D=0, IR=0, Mreg=0, PC=RESET_PC. State=FETCH.
  - Outputs: mem_rd=0, mem_wr=0, mem_addr=0, mem_wdata=0.
  - Reset mid-request aborts the request immediately; the late mem_ack is ignored after reset release.
- States: FETCH, MREAD, EXEC, MWRITE.
- FETCH:
  - instr_ready=1, only in this state.
  - On instr_valid, IR<=instr.
  - IR[15]=0 (A-instr): A<=instr, PC<=PC+1, stay in FETCH. One instruction per cycle.
  - IR[15]=1 and IR[12]=1: next state MREAD.
  - IR[15]=1 and IR[12]=0: next state EXEC.
  - IR[14:13] are ignored.
- MREAD:
  - mem_rd=1, mem_addr=A[14:0].
  - On mem_ack, Mreg<=mem_rdata and go to EXEC.
  - Waits indefinitely without ack.
- EXEC (exactly 1 cycle):
  - Drive alu_x=D, alu_y=(IR[12]?Mreg:A), alu_c=IR[11:6]. These are driven from registers in all states; valid for the ALU in EXEC.
  - Destinations: IR[5]=1 -> A<=alu_out; IR[4]=1 -> D<=alu_out.
  - IR[3]=1: latch mem_wdata<=alu_out and mem_addr<=A_old[14:0], go to MWRITE. Otherwise go to FETCH.
  - The write address always uses the pre-update A, including when dest includes both A and M.
- Jump in EXEC:
  - take = (IR[2]&ng) | (IR[1]&zr) | (IR[0]&~ng&~zr).
  - take=1 -> PC<=A_old[14:0]; else PC<=PC+1.
  - jjj=111 is an unconditional jump.
- MWRITE:
  - mem_wr=1 with the latched addr/data held stable.
  - On mem_ack, go to FETCH and deassert mem_wr the next cycle.
- mem_rd and mem_wr are never asserted together.
- PC arithmetic is 15-bit and wraps: 15'h7FFF+1 -> 15'h0000.
- alu_out is not registered inside the ALU; it is sampled only on the EXEC edge.
- Latency:
  - A-instr: 1 cycle.
  - C-instr without M: 2 cycles.
  - Read adds 1+wait cycles; write adds 1+wait cycles.
- mem_ack outside MREAD/MWRITE is ignored.

Decomposition:
- Package hack_pkg:
  - State enum (FETCH, MREAD, EXEC, MWRITE).
  - IR field constants: TYPE_BIT=15, A_BIT=12, C_MSB=11, C_LSB=6, DEST_A=5, DEST_D=4, DEST_M=3, J_MSB=2.
  - ALU control codes: ZERO=6'b101010, ONE=6'b111111, X=6'b001100, X_PLUS_Y=6'b000010.
- Sub-module: hack_jump_unit, a combinational (jjj, zr, ng) -> take.

Test Plan:
1. Reset then instr=16'h0005 valid -> after 1 cycle A=5, pc=1, instr_ready stays high.
2. A=5, then instr=16'hEC10 (D=A) -> alu_c=6'b110000, next edge D=5, pc=2, no mem traffic.
3. A=7, instr=16'hFC10 (D=M), mem_ack 3 cycles late with rdata=16'h1234 -> mem_rd high 3 cycles at addr 7, D=16'h1234 in EXEC, pc incremented.
4. D=5, A=9, instr=16'hE0A8 (AM=D+A; ALU out 14) -> mem_wr at addr 9 (old A) with data 14, A=14, held until ack.
5. A=16'h0040, D=0, instr=16'hE302 (D;JEQ) -> zr=1, pc=16'h0040. Repeat with D=1 -> pc=old+1.
6. pc=15'h7FFF with an A-instr -> pc wraps to 0. rst_n low during MREAD -> mem_rd drops asynchronously, pc=RESET_PC.
